ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder.sv | 127 ++++++++++++
 tb/tb_ram_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Word-addressed RAM responder with a programmable BUSY latency and a FREE/BUSY/ACCESS/ERROR handshake.
// Define RAM_ADDR_CHECK_EN to send misaligned or out-of-range addresses to ERROR instead of wrapping.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT       = 2,
  parameter int ADDR_BITS = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output ramstate_t   ramstate
);

  localparam int         DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0] RELOAD = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  ramstate_t            state, state_n;
  logic [3:0]           cnt, cnt_n;
  logic [31:0]          lat_addr, lat_store;
  logic                 lat_wr;
  logic                 latch_req;
  logic                 do_access;
  logic                 one_req, both_req, changed, bad_addr;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          mem [DEPTH];

  assign idx      = ramaddr[ADDR_BITS+1:2];
  assign one_req  = ramREN ^ ramWEN;
  assign both_req = ramREN & ramWEN;
  assign changed  = (ramaddr != lat_addr) || (ramWEN != lat_wr) ||
                    (ramWEN && (ramstore != lat_store));
  assign ramstate = state;

`ifdef RAM_ADDR_CHECK_EN
  assign bad_addr = (ramaddr[1:0] != 2'b00) || ((ramaddr >> (ADDR_BITS + 2)) != 32'd0);
`else
  assign bad_addr = 1'b0;
`endif

  // A request only reaches ACCESS once its inputs have been stable for the full
  // latency, so the live inputs equal the latched copy on the completing edge.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    latch_req = 1'b0;
    do_access = 1'b0;
    case (state)
      BUSY: begin
        if (both_req) begin
          state_n = ERROR;
        end else if (!one_req) begin
          state_n = FREE;
        end else if (bad_addr) begin
          state_n = ERROR;
        end else if (changed) begin
          latch_req = 1'b1;
          cnt_n     = RELOAD;
        end else if (cnt == 4'd0) begin
          state_n   = ACCESS;
          do_access = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        if (both_req) begin
          state_n = ERROR;
        end else if (!one_req) begin
          state_n = FREE;
        end else if (bad_addr) begin
          state_n = ERROR;
        end else begin
          latch_req = 1'b1;
          if (LAT == 0) begin
            state_n   = ACCESS;
            do_access = 1'b1;
            cnt_n     = 4'd0;
          end else begin
            state_n = BUSY;
            cnt_n   = RELOAD;
          end
        end
      end
    endcase
  end

  // Reset clears the whole array so a write pending at reset can never surface later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= FREE;
      cnt       <= 4'd0;
      lat_addr  <= 32'd0;
      lat_store <= 32'd0;
      lat_wr    <= 1'b0;
      ramload   <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch_req) begin
        lat_addr  <= ramaddr;
        lat_store <= ramstore;
        lat_wr    <= ramWEN;
      end
      if (do_access) begin
        if (ramWEN) begin
          mem[idx] <= ramstore;
          ramload  <= ramstore;
        end else begin
          ramload <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: one LAT=2 instance and one LAT=0 instance,
// with read data checked by per-instance monitors whenever ACCESS is presented.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren, wen, ren0, wen0;
  logic [31:0] addr, store, load, addr0, store0, load0;
  ramstate_t   state, state0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ[$];
  logic [31:0] expQ0[$];

  ram_responder #(.LAT(2), .ADDR_BITS(10)) dut (
    .CLK(clk), .RST(rst), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
    .ramstore(store), .ramload(load), .ramstate(state)
  );

  ram_responder #(.LAT(0), .ADDR_BITS(10)) dut0 (
    .CLK(clk), .RST(rst), .ramREN(ren0), .ramWEN(wen0), .ramaddr(addr0),
    .ramstore(store0), .ramload(load0), .ramstate(state0)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monLat2
    logic [31:0] e;
    if (state == ACCESS) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL lat2 unexpected ACCESS actual load=%h required none", load);
      end else begin
        e = expQ.pop_front();
        if (load !== e) begin
          errors++;
          $display("[TB] FAIL lat2 ramload actual=%h required=%h", load, e);
        end
      end
    end
  end

  always @(negedge clk) begin : monLat0
    logic [31:0] e;
    if (state0 == ACCESS) begin
      checks++;
      if (expQ0.size() == 0) begin
        errors++;
        $display("[TB] FAIL lat0 unexpected ACCESS actual load=%h required none", load0);
      end else begin
        e = expQ0.pop_front();
        if (load0 !== e) begin
          errors++;
          $display("[TB] FAIL lat0 ramload actual=%h required=%h", load0, e);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ren = r; wen = w; addr = a; store = d;
  endtask

  task automatic applyStimulus0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ren0 = r; wen0 = w; addr0 = a; store0 = d;
  endtask

  task automatic waitState(input string name, input ramstate_t exp);
    @(negedge clk);
    checkOutput(name, 32'(state), 32'(exp));
  endtask

  task automatic waitState0(input string name, input ramstate_t exp);
    @(negedge clk);
    checkOutput(name, 32'(state0), 32'(exp));
  endtask

  // One complete LAT=2 transaction: request, two BUSY cycles, ACCESS, release.
  task automatic doTxn(input string name, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] expLoad);
    expQ.push_back(expLoad);
    applyStimulus(!w, w, a, d);
    waitState({name, " busy1"}, BUSY);
    waitState({name, " busy2"}, BUSY);
    waitState({name, " access"}, ACCESS);
    applyStimulus(1'b0, 1'b0, a, d);
    waitState({name, " free"}, FREE);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    applyStimulus0(1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset state", 32'(state), 32'(FREE));
    checkOutput("reset load", load, 32'd0);
    checkOutput("reset state lat0", 32'(state0), 32'(FREE));

    doTxn("wr40", 1'b1, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF);
    doTxn("rd40", 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
    checkOutput("load hold", load, 32'hDEADBEEF);

    doTxn("wr14", 1'b1, 32'h14, 32'h55AA55AA, 32'h55AA55AA);
    doTxn("wr10", 1'b1, 32'h10, 32'h11111111, 32'h11111111);

    // Address moves during the second BUSY cycle: the countdown restarts.
    expQ.push_back(32'h55AA55AA);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    waitState("restart busy1", BUSY);
    waitState("restart busy2", BUSY);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0);
    waitState("restart busy3", BUSY);
    waitState("restart busy4", BUSY);
    waitState("restart access", ACCESS);
    applyStimulus(1'b0, 1'b0, 32'h14, 32'h0);
    waitState("restart free", FREE);

    applyStimulus(1'b1, 1'b1, 32'h40, 32'h0);
    waitState("both err1", ERROR);
    waitState("both err2", ERROR);
    waitState("both err3", ERROR);
    checkOutput("error load hold", load, 32'h55AA55AA);
    expQ.push_back(32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    waitState("after err busy1", BUSY);
    waitState("after err busy2", BUSY);
    waitState("after err access", ACCESS);
    applyStimulus(1'b0, 1'b0, 32'h40, 32'h0);
    waitState("after err free", FREE);

    // Reset lands on the edge that would otherwise commit the write.
    applyStimulus(1'b0, 1'b1, 32'h8, 32'h1234);
    waitState("rstwr busy1", BUSY);
    waitState("rstwr busy2", BUSY);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h8, 32'h0);
    checkOutput("mid reset state", 32'(state), 32'(FREE));
    checkOutput("mid reset load", load, 32'd0);
    doTxn("rd8 after rst", 1'b0, 32'h8, 32'h0, 32'h0);
    doTxn("rd40 after rst", 1'b0, 32'h40, 32'h0, 32'h0);

    expQ.push_back(32'hCAFEF00D);
    expQ.push_back(32'hCAFEF00D);
    applyStimulus(1'b0, 1'b1, 32'h8, 32'hCAFEF00D);
    waitState("b2b busy1", BUSY);
    waitState("b2b busy2", BUSY);
    waitState("b2b access1", ACCESS);
    waitState("b2b busy3", BUSY);
    waitState("b2b busy4", BUSY);
    waitState("b2b access2", ACCESS);
    applyStimulus(1'b0, 1'b0, 32'h8, 32'h0);
    waitState("b2b free", FREE);
    doTxn("rd8 b2b", 1'b0, 32'h8, 32'h0, 32'hCAFEF00D);

`ifdef RAM_ADDR_CHECK_EN
    applyStimulus(1'b1, 1'b0, 32'h2, 32'h0);
    waitState("misaligned err1", ERROR);
    waitState("misaligned err2", ERROR);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitState("misaligned free", FREE);
`else
    doTxn("wr0", 1'b1, 32'h0, 32'h13579BDF, 32'h13579BDF);
    doTxn("rd1000 wrap", 1'b0, 32'h1000, 32'h0, 32'h13579BDF);
    doTxn("wr100b wrap", 1'b1, 32'h100B, 32'h2468ACE0, 32'h2468ACE0);
    doTxn("rd8 wrap", 1'b0, 32'h8, 32'h0, 32'h2468ACE0);
`endif

    expQ0.push_back(32'hA5A5A5A5);
    applyStimulus0(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5);
    waitState0("lat0 wr access", ACCESS);
    applyStimulus0(1'b0, 1'b0, 32'h0, 32'h0);
    waitState0("lat0 wr free", FREE);

    repeat (3) expQ0.push_back(32'hA5A5A5A5);
    applyStimulus0(1'b1, 1'b0, 32'h0, 32'h0);
    waitState0("lat0 rd access1", ACCESS);
    waitState0("lat0 rd access2", ACCESS);
    waitState0("lat0 rd access3", ACCESS);
    applyStimulus0(1'b0, 1'b0, 32'h0, 32'h0);
    waitState0("lat0 rd free", FREE);

    checkOutput("queues drained", 32'(expQ.size() + expQ0.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
